// File: rtl/fx3_socket_arbiter_pkg.sv
// Shared FX3 arbiter definitions: FSM encodings, socket direction bits and
// the index-width helper used by the arbiter and its round-robin selectors.
package fx3_socket_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IN_ACTIVE,
    ST_OUT_ARM,
    ST_OUT_DMA,
    ST_OUT_WAIT
  } arb_state_e;

  // MSB of the FX3 socket address selects the transfer direction.
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fx3_socket_arbiter_if.sv
// Handshake bundle between the FX3 socket arbiter (master) and the
// input/output path logic plus FX3 socket flags (slave).
interface fx3_socket_arbiter_if #(
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 2,
  parameter int SOCK_W       = 4
);
  logic                    i_master_rdy;
  logic                    o_in_path_enable;
  logic                    i_in_path_busy;
  logic                    i_in_path_finished;
  logic                    o_in_path_cmd_enable;
  logic                    i_out_path_ready;
  logic                    o_out_path_enable;
  logic                    i_out_path_busy;
  logic                    i_out_path_finished;
  logic                    o_out_dma_buf_ready;
  logic                    i_out_dma_buf_finished;
  logic [IN_CHANNELS-1:0]  i_in_ch_rdy;
  logic [OUT_CHANNELS-1:0] i_out_ch_rdy;
  logic [SOCK_W-1:0]       o_socket_addr;
  logic                    o_timeout_stb;
  logic [15:0]             o_out_buf_count;

  modport master (
    input  i_master_rdy, i_in_path_busy, i_in_path_finished, i_out_path_ready,
           i_out_path_busy, i_out_path_finished, i_out_dma_buf_finished,
           i_in_ch_rdy, i_out_ch_rdy,
    output o_in_path_enable, o_in_path_cmd_enable, o_out_path_enable,
           o_out_dma_buf_ready, o_socket_addr, o_timeout_stb, o_out_buf_count
  );

  modport slave (
    output i_master_rdy, i_in_path_busy, i_in_path_finished, i_out_path_ready,
           i_out_path_busy, i_out_path_finished, i_out_dma_buf_finished,
           i_in_ch_rdy, i_out_ch_rdy,
    input  o_in_path_enable, o_in_path_cmd_enable, o_out_path_enable,
           o_out_dma_buf_ready, o_socket_addr, o_timeout_stb, o_out_buf_count
  );

endinterface

// File: rtl/fx3_socket_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after `start`,
// wrapping modulo N, plus the start position for the following search.
module fx3_rr_select
  import fx3_socket_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] next
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    // Scan farthest offset first so the nearest set request overwrites it.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(start) + k) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(start) + k) % N);
      end
    end
    next = (int'(idx) == N - 1) ? '0 : idx + IW'(1);
  end

endmodule

// File: rtl/fx3_socket_arbiter.sv
// FX3 socket arbiter: grants the input path or the output path (alternating
// under contention), sequences output DMA buffers and guards paths with a timeout.
module fx3_socket_arbiter
  import fx3_socket_arbiter_pkg::*;
#(
  parameter int IN_CHANNELS    = 2,
  parameter int OUT_CHANNELS   = 2,
  parameter int SOCK_W         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  rst,
  fx3_socket_arbiter_if.master bus
);

  localparam int          IN_IW  = idx_w(IN_CHANNELS);
  localparam int          OUT_IW = idx_w(OUT_CHANNELS);
  localparam logic [31:0] TMO    = 32'(TIMEOUT_CYCLES);

  arb_state_e        state, state_d;
  logic              in_en, in_en_d, out_en, out_en_d, dma_rdy, dma_rdy_d;
  logic              cmd_en, cmd_en_d, tmo_stb, tmo_stb_d, last_dir, last_dir_d;
  logic [SOCK_W-1:0] sock_addr, sock_addr_d;
  logic [15:0]       buf_cnt, buf_cnt_d;
  logic [31:0]       tmr, tmr_d;
  logic [IN_IW-1:0]  in_ptr, in_ptr_d, in_idx, in_next;
  logic [OUT_IW-1:0] out_ptr, out_ptr_d, out_idx, out_next;
  logic              in_valid, out_valid, in_req, out_req;

  fx3_rr_select #(.N(IN_CHANNELS)) u_in_rr (
    .req(bus.i_in_ch_rdy), .start(in_ptr), .valid(in_valid), .idx(in_idx), .next(in_next)
  );

  fx3_rr_select #(.N(OUT_CHANNELS)) u_out_rr (
    .req(bus.i_out_ch_rdy), .start(out_ptr), .valid(out_valid), .idx(out_idx), .next(out_next)
  );

  assign in_req  = bus.i_master_rdy && in_valid;
  assign out_req = bus.i_out_path_ready;

  always_comb begin
    state_d     = state;
    in_en_d     = in_en;
    out_en_d    = out_en;
    dma_rdy_d   = dma_rdy;
    cmd_en_d    = cmd_en;
    tmo_stb_d   = 1'b0;
    last_dir_d  = last_dir;
    sock_addr_d = sock_addr;
    buf_cnt_d   = buf_cnt;
    tmr_d       = tmr + 32'd1;
    in_ptr_d    = in_ptr;
    out_ptr_d   = out_ptr;

    case (state)
      ST_IDLE: begin
        tmr_d = '0;
        // Under contention the direction not served last time wins.
        if (in_req && (!out_req || last_dir == DIR_OUT)) begin
          sock_addr_d = {DIR_IN, (SOCK_W-1)'(in_idx)};
          in_ptr_d    = in_next;
          in_en_d     = 1'b1;
          last_dir_d  = DIR_IN;
          state_d     = ST_IN_ACTIVE;
        end else if (out_req) begin
          out_en_d   = 1'b1;
          buf_cnt_d  = '0;
          last_dir_d = DIR_OUT;
          state_d    = ST_OUT_ARM;
        end
      end
      ST_IN_ACTIVE: begin
        if (bus.i_in_path_finished) begin
          in_en_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_OUT_ARM: begin
        if (bus.i_out_path_finished) begin
          out_en_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (out_valid) begin
          sock_addr_d = {DIR_OUT, (SOCK_W-1)'(out_idx)};
          out_ptr_d   = out_next;
          dma_rdy_d   = 1'b1;
          state_d     = ST_OUT_DMA;
        end
      end
      ST_OUT_DMA: begin
        if (bus.i_out_dma_buf_finished) begin
          dma_rdy_d = 1'b0;
          buf_cnt_d = (buf_cnt == 16'hFFFF) ? buf_cnt : buf_cnt + 16'd1;
          tmr_d     = '0;
          state_d   = ST_OUT_WAIT;
        end
        if (bus.i_out_path_finished) begin
          dma_rdy_d = 1'b0;
          out_en_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_OUT_WAIT: begin
        if (bus.i_out_path_finished) begin
          out_en_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_OUT_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A path that stays busy too long is torn down; an arm on that edge is abandoned.
    if (TIMEOUT_CYCLES != 0 && state != ST_IDLE && state_d != ST_IDLE && tmr_d == TMO) begin
      state_d     = ST_IDLE;
      in_en_d     = 1'b0;
      out_en_d    = 1'b0;
      dma_rdy_d   = 1'b0;
      tmo_stb_d   = 1'b1;
      tmr_d       = '0;
      sock_addr_d = sock_addr;
      out_ptr_d   = out_ptr;
    end

    if (bus.i_master_rdy) begin
      cmd_en_d = 1'b1;
    end else if (state == ST_IDLE && !out_req) begin
      cmd_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples the pre-edge values.
    if (rst) begin
      state     <= ST_IDLE;
      in_en     <= 1'b0;
      out_en    <= 1'b0;
      dma_rdy   <= 1'b0;
      cmd_en    <= 1'b0;
      tmo_stb   <= 1'b0;
      last_dir  <= DIR_OUT;
      sock_addr <= '0;
      buf_cnt   <= '0;
      tmr       <= '0;
      in_ptr    <= '0;
      out_ptr   <= '0;
    end else begin
      state     <= state_d;
      in_en     <= in_en_d;
      out_en    <= out_en_d;
      dma_rdy   <= dma_rdy_d;
      cmd_en    <= cmd_en_d;
      tmo_stb   <= tmo_stb_d;
      last_dir  <= last_dir_d;
      sock_addr <= sock_addr_d;
      buf_cnt   <= buf_cnt_d;
      tmr       <= tmr_d;
      in_ptr    <= in_ptr_d;
      out_ptr   <= out_ptr_d;
    end
  end

  assign bus.o_in_path_enable     = in_en;
  assign bus.o_out_path_enable    = out_en;
  assign bus.o_out_dma_buf_ready  = dma_rdy;
  assign bus.o_in_path_cmd_enable = cmd_en;
  assign bus.o_timeout_stb        = tmo_stb;
  assign bus.o_socket_addr        = sock_addr;
  assign bus.o_out_buf_count      = buf_cnt;

endmodule

// File: tb/tb_fx3_socket_arbiter.sv
// Scoreboard bench for fx3_socket_arbiter: expected grants, addresses and
// buffer counts are queued as stimulus is driven and popped as the DUT responds.
module tb_fx3_socket_arbiter;

  localparam int W_IN  = 0;
  localparam int W_OUT = 1;
  localparam int W_DMA = 2;
  localparam int W_ANY = 3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fx3_socket_arbiter_if #(.IN_CHANNELS(2), .OUT_CHANNELS(2), .SOCK_W(4)) bus ();

  fx3_socket_arbiter #(
    .IN_CHANNELS(2), .OUT_CHANNELS(2), .SOCK_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      W_IN:    return bus.o_in_path_enable;
      W_OUT:   return bus.o_out_path_enable;
      W_DMA:   return bus.o_out_dma_buf_ready;
      default: return bus.o_in_path_enable | bus.o_out_path_enable;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (sel_sig(which) !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(sel_sig(which) === 1'b1), 32'd1);
    check({tag, "_excl"}, 32'(bus.o_in_path_enable & bus.o_out_path_enable), 32'd0);
  endtask

  task automatic do_reset();
    rst                        = 1'b1;
    bus.i_master_rdy           = 1'b0;
    bus.i_in_path_busy         = 1'b0;
    bus.i_in_path_finished     = 1'b0;
    bus.i_out_path_ready       = 1'b0;
    bus.i_out_path_busy        = 1'b0;
    bus.i_out_path_finished    = 1'b0;
    bus.i_out_dma_buf_finished = 1'b0;
    bus.i_in_ch_rdy            = '0;
    bus.i_out_ch_rdy           = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_en"},   32'(bus.o_in_path_enable),     32'd0);
    check({tag, "_out_en"},  32'(bus.o_out_path_enable),    32'd0);
    check({tag, "_dma_rdy"}, 32'(bus.o_out_dma_buf_ready),  32'd0);
    check({tag, "_cmd_en"},  32'(bus.o_in_path_cmd_enable), 32'd0);
    check({tag, "_addr"},    32'(bus.o_socket_addr),        32'd0);
    check({tag, "_tmo"},     32'(bus.o_timeout_stb),        32'd0);
    check({tag, "_count"},   32'(bus.o_out_buf_count),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic early;

    do_reset();
    check_all_zero("reset");

    // Simultaneous requests: input wins first, then direction alternates.
    do_reset();
    bus.i_in_ch_rdy      = 2'b01;
    bus.i_master_rdy     = 1'b1;
    bus.i_out_path_ready = 1'b1;
    push("b_out_dir1", 0); push("b_addr1", 4'h0);
    push("b_out_dir2", 1); push("b_addr2", 4'h0);
    push("b_out_dir3", 0); push("b_addr3", 4'h0);
    for (int g = 0; g < 3; g++) begin
      wait_for(W_ANY, "b_grant");
      pop_check(32'(bus.o_out_path_enable));
      pop_check(32'(bus.o_socket_addr));
      if (bus.o_in_path_enable) bus.i_in_path_finished = 1'b1;
      else bus.i_out_path_finished = 1'b1;
      step();
      bus.i_in_path_finished  = 1'b0;
      bus.i_out_path_finished = 1'b0;
      check("b_release", 32'(bus.o_in_path_enable | bus.o_out_path_enable), 32'd0);
    end

    // Input round-robin over two ready sockets.
    do_reset();
    bus.i_in_ch_rdy  = 2'b11;
    bus.i_master_rdy = 1'b1;
    push("a_addr1", 4'h0); push("a_addr2", 4'h1); push("a_addr3", 4'h0);
    for (int g = 0; g < 3; g++) begin
      wait_for(W_IN, "a_grant");
      pop_check(32'(bus.o_socket_addr));
      check("a_cmd_en", 32'(bus.o_in_path_cmd_enable), 32'd1);
      bus.i_in_path_finished = 1'b1;
      step();
      bus.i_in_path_finished = 1'b0;
      check("a_release", 32'(bus.o_in_path_enable), 32'd0);
    end

    // Output transaction with three DMA buffers on socket 1.
    do_reset();
    bus.i_out_ch_rdy     = 2'b10;
    bus.i_out_path_ready = 1'b1;
    wait_for(W_OUT, "c_grant");
    check("c_count_clr", 32'(bus.o_out_buf_count), 32'd0);
    bus.i_out_path_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_for(W_DMA, "c_arm");
      check("c_arm_addr", 32'(bus.o_socket_addr), 32'h9);
      push("c_count", 32'(k));
      bus.i_out_dma_buf_finished = 1'b1;
      step();
      bus.i_out_dma_buf_finished = 1'b0;
      pop_check(32'(bus.o_out_buf_count));
      check("c_dma_clr", 32'(bus.o_out_dma_buf_ready), 32'd0);
    end
    bus.i_out_path_finished = 1'b1;
    step();
    bus.i_out_path_finished = 1'b0;
    check("c_end_en", 32'(bus.o_out_path_enable), 32'd0);
    check("c_end_count", 32'(bus.o_out_buf_count), 32'd3);
    check("c_end_addr", 32'(bus.o_socket_addr), 32'h9);

    // Path finish coincident with buffer finish.
    do_reset();
    bus.i_out_ch_rdy     = 2'b01;
    bus.i_out_path_ready = 1'b1;
    wait_for(W_OUT, "d_grant");
    bus.i_out_path_ready = 1'b0;
    wait_for(W_DMA, "d_arm");
    check("d_arm_addr", 32'(bus.o_socket_addr), 32'h8);
    push("d_count", 32'd1);
    bus.i_out_dma_buf_finished = 1'b1;
    bus.i_out_path_finished    = 1'b1;
    step();
    bus.i_out_dma_buf_finished = 1'b0;
    bus.i_out_path_finished    = 1'b0;
    pop_check(32'(bus.o_out_buf_count));
    check("d_en", 32'(bus.o_out_path_enable), 32'd0);
    check("d_dma", 32'(bus.o_out_dma_buf_ready), 32'd0);
    step();
    check("d_idle", 32'(bus.o_in_path_enable | bus.o_out_path_enable), 32'd0);

    // Input path never finishes: timeout after 16 enabled cycles.
    do_reset();
    bus.i_in_ch_rdy  = 2'b01;
    bus.i_master_rdy = 1'b1;
    wait_for(W_IN, "e_grant");
    bus.i_in_ch_rdy = 2'b00;
    push("e_enabled_cycles", 32'd16);
    n = 0;
    early = 1'b0;
    while (bus.o_in_path_enable === 1'b1 && n < 40) begin
      if (bus.o_timeout_stb) early = 1'b1;
      step();
      n++;
    end
    pop_check(32'(n));
    check("e_early_stb", 32'(early), 32'd0);
    check("e_stb", 32'(bus.o_timeout_stb), 32'd1);
    step();
    check("e_stb_pulse", 32'(bus.o_timeout_stb), 32'd0);
    check("e_idle", 32'(bus.o_in_path_enable | bus.o_out_path_enable), 32'd0);

    // Reset while a DMA buffer is armed, then a normal input grant.
    do_reset();
    bus.i_out_ch_rdy     = 2'b10;
    bus.i_out_path_ready = 1'b1;
    wait_for(W_OUT, "f_grant");
    bus.i_out_path_ready = 1'b0;
    wait_for(W_DMA, "f_arm");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("f_rst");
    bus.i_in_ch_rdy  = 2'b10;
    bus.i_master_rdy = 1'b1;
    push("f_addr", 4'h1);
    wait_for(W_IN, "f_regrant");
    pop_check(32'(bus.o_socket_addr));

    // Command decoder enable follows master readiness while idle.
    do_reset();
    bus.i_master_rdy = 1'b1;
    step();
    check("g_cmd_set", 32'(bus.o_in_path_cmd_enable), 32'd1);
    bus.i_master_rdy = 1'b0;
    step();
    check("g_cmd_clr", 32'(bus.o_in_path_cmd_enable), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx3_socket_arbiter.md
FX3_SOCKET_ARBITER -- requirements
Module: fx3_socket_arbiter

Interface
REQ-001 SHALL have parameter IN_CHANNELS, default 2, number of FX3 input (host->FPGA) sockets, range 1..8.
REQ-002 SHALL have parameter OUT_CHANNELS, default 2, number of FX3 output (FPGA->host) sockets, range 1..8.
REQ-003 SHALL have parameter SOCK_W, default 4, o_socket_addr width; MSB = direction, low SOCK_W-1 bits = channel index; SOCK_W-1 >= clog2(max(IN_CHANNELS,OUT_CHANNELS)).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, cycles a path may stay enabled without finishing; 0 disables timeout.
REQ-005 SHALL use clock clk; reset rst, synchronous, active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 i_master_rdy  in  1  master can accept/produce transactions.
REQ-009 o_in_path_enable  out  1  grant to input path; i_in_path_busy in 1, i_in_path_finished in 1 (one-cycle strobe).
REQ-010 o_in_path_cmd_enable  out  1  command decoder enable.
REQ-011 i_out_path_ready  in  1  output path has data; o_out_path_enable out 1; i_out_path_busy in 1; i_out_path_finished in 1 (strobe).
REQ-012 o_out_dma_buf_ready  out  1  output DMA buffer armed; i_out_dma_buf_finished in 1 (strobe).
REQ-013 i_in_ch_rdy  in  IN_CHANNELS  per-socket input data-available flags.
REQ-014 i_out_ch_rdy  in  OUT_CHANNELS  per-socket output buffer-available flags.
REQ-015 o_socket_addr  out  SOCK_W  FX3 socket address.
REQ-016 o_timeout_stb  out  1  one-cycle strobe on path timeout.
REQ-017 o_out_buf_count  out  16  DMA buffers completed in current output transaction, saturating at 0xFFFF.

Function
REQ-018 FSM states SHALL be IDLE, IN_ACTIVE, OUT_ARM, OUT_DMA, OUT_WAIT; at most one of o_in_path_enable, o_out_path_enable asserted in any cycle.
REQ-019 IDLE: input request = i_master_rdy && |i_in_ch_rdy; output request = i_out_path_ready; single request granted on the next edge; both pending -> grant direction opposite to last granted (last_dir resets to output, so input wins first).
REQ-020 Input grant SHALL register o_socket_addr = {0, idx}, idx = round-robin winner among set i_in_ch_rdy bits starting at last input idx+1 modulo IN_CHANNELS, set o_in_path_enable, enter IN_ACTIVE.
REQ-021 IN_ACTIVE: on i_in_path_finished clear o_in_path_enable next edge, go IDLE.
REQ-022 Output grant SHALL set o_out_path_enable, clear o_out_buf_count, enter OUT_ARM.
REQ-023 OUT_ARM: if i_out_path_finished -> clear enable, go IDLE; else if |i_out_ch_rdy -> o_socket_addr = {1, round-robin output idx}, o_out_dma_buf_ready = 1, go OUT_DMA.
REQ-024 OUT_DMA: on i_out_dma_buf_finished clear o_out_dma_buf_ready, increment o_out_buf_count, go OUT_WAIT.
REQ-025 OUT_WAIT: one-cycle settle, then OUT_ARM; i_out_path_finished here clears enable, go IDLE.
REQ-026 i_out_path_finished coincident with i_out_dma_buf_finished in OUT_DMA SHALL count the buffer, clear both outputs, go IDLE.
REQ-027 Round-robin pointers SHALL advance only on grant; no ready bit -> no grant, pointer unchanged; indices >= channel count never produced.
REQ-028 Timeout counter SHALL reset on every grant and each i_out_dma_buf_finished, count while in IN_ACTIVE/OUT_*; reaching TIMEOUT_CYCLES deasserts all enables, pulses o_timeout_stb one cycle, returns IDLE.
REQ-029 o_in_path_cmd_enable SHALL set when i_master_rdy=1 and clear when i_master_rdy=0 and FSM in IDLE with no pending request.
REQ-030 o_socket_addr SHALL hold its value outside grant/arm updates.

Reset
REQ-031 rst SHALL force IDLE and all outputs 0: enables, o_out_dma_buf_ready, o_socket_addr, o_timeout_stb, o_out_buf_count; pointers 0; last_dir = output.
REQ-032 rst mid-transaction SHALL drop enables on the same edge with no timeout strobe.

Structure
REQ-033 FSM state encodings and socket direction bit constants SHALL reside in a shared fx3 package/include.
REQ-034 Round-robin selector SHALL be one sub-module, fx3_rr_select, instantiated twice (N = IN_CHANNELS, OUT_CHANNELS).

Verification
REQ-035 i_in_ch_rdy=2'b11 held, master ready, 3 input transactions -> socket addresses 0x0, 0x1, 0x0.
REQ-036 Input and output requests simultaneous from IDLE, repeated -> grants alternate in, out, in.
REQ-037 Output transaction, i_out_ch_rdy=2'b10, 3 DMA buffers then finished -> o_socket_addr=0x9, o_out_buf_count=3, enable low.
REQ-038 TIMEOUT_CYCLES=16, input granted, no finished -> enable drops after 16 cycles, o_timeout_stb one cycle, IDLE.
REQ-039 rst asserted in OUT_DMA -> next cycle all outputs 0; subsequent request from IDLE granted normally.
REQ-040 i_out_path_finished with i_out_dma_buf_finished same cycle -> count increments once, IDLE.
